minimac2_esync: RTL and testbench



---
 rtl/minimac2_esync.sv | 120 ++++++++++++
 tb/tb_minimac2_esync.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/minimac2_esync.sv
// Multi-channel toggle event synchronizer for the sys_clk domain.
// Each toggle edge becomes one pending event, drained by a valid/ack handshake.
module minimac2_esync #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned CW       = 4
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [CHANNELS-1:0]    toggle_i,
    output logic [CHANNELS-1:0]    pulse_o,
    output logic [CHANNELS-1:0]    valid_o,
    input  logic [CHANNELS-1:0]    ack_i,
    output logic [CHANNELS*CW-1:0] count_o,
    output logic [CHANNELS-1:0]    ovf_o,
    input  logic [CHANNELS-1:0]    ovf_clr_i
);

    localparam int unsigned AW = $clog2(DEPTH + 2);
    localparam logic [AW-1:0] ARM_DONE = AW'(DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    // Stage-major chain: sync_q[0] is the only flop sampling toggle_i.
    logic [DEPTH-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0]            prev_q;

    logic [AW-1:0] arm_q;
    logic [AW-1:0] arm_d;
    logic          armed_c;

    logic [CHANNELS-1:0][CW-1:0] cnt_q;
    logic [CHANNELS-1:0][CW-1:0] cnt_d;
    logic [CHANNELS-1:0]         valid_q;
    logic [CHANNELS-1:0]         valid_d;
    logic [CHANNELS-1:0]         ovf_q;
    logic [CHANNELS-1:0]         ovf_d;
    logic [CHANNELS-1:0]         inc_c;
    logic [CHANNELS-1:0]         dec_c;
    logic [CHANNELS-1:0]         sat_c;

    // Synchronizer chain and edge-history register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], toggle_i};
            prev_q <= sync_q[DEPTH-1];
        end
    end

    // Arming counter: state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            arm_q <= '0;
        end else begin
            arm_q <= arm_d;
        end
    end

    // Arming counter: next state, saturating at ARM_DONE.
    always_comb begin
        arm_d = arm_q;
        if (arm_q != ARM_DONE) begin
            arm_d = arm_q + AW'(1);
        end
    end

    // Arming counter: output decode.
    always_comb begin
        armed_c = (arm_q == ARM_DONE);
    end

    // Edges seen before arming only realign prev with the input level.
    assign pulse_o = (sync_q[DEPTH-1] ^ prev_q) & {CHANNELS{armed_c}};
    assign inc_c   = pulse_o;
    assign dec_c   = ack_i & valid_q;

    // Pending counter and sticky overflow; a coincident inc/dec cancels out.
    always_comb begin
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sat_c   = '0;
        valid_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (inc_c[i] && !dec_c[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    sat_c[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else if (dec_c[i] && !inc_c[i]) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
            if (sat_c[i]) begin
                ovf_d[i] = 1'b1;
            end else if (ovf_clr_i[i]) begin
                ovf_d[i] = 1'b0;
            end
            valid_d[i] = (cnt_d[i] != '0);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q   <= '0;
            valid_q <= '0;
            ovf_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = cnt_q;
    assign valid_o = valid_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_minimac2_esync.sv
// Self-checking bench for minimac2_esync: directed test-plan steps plus a
// randomized phase, all compared every cycle against a sample-history model.
module tb_minimac2_esync;

    localparam int CH    = 4;
    localparam int DEPTH = 2;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;
    localparam int HN    = 4096;

    logic               sys_clk;
    logic               sys_rst;
    logic [CH-1:0]      toggle_i;
    logic [CH-1:0]      pulse_o;
    logic [CH-1:0]      valid_o;
    logic [CH-1:0]      ack_i;
    logic [CH*CW-1:0]   count_o;
    logic [CH-1:0]      ovf_o;
    logic [CH-1:0]      ovf_clr_i;

    minimac2_esync #(.CHANNELS(CH), .DEPTH(DEPTH), .CW(CW)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .toggle_i  (toggle_i),
        .pulse_o   (pulse_o),
        .valid_o   (valid_o),
        .ack_i     (ack_i),
        .count_o   (count_o),
        .ovf_o     (ovf_o),
        .ovf_clr_i (ovf_clr_i)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Model: input level sampled at each edge (0 where reset cleared it).
    logic [CH-1:0] hist [HN];
    int            n        = 16;
    int            last_rst = 0;
    int            m_cnt [CH];
    logic [CH-1:0] m_ovf    = '0;
    logic [CH-1:0] m_pulse  = '0;
    int            pseen [CH];
    int            last_tog [CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic tick();
        logic [CH*CW-1:0] exp_cnt;
        logic [CH-1:0]    exp_val;
        @(posedge sys_clk);
        n++;
        if (sys_rst) begin
            for (int k = 0; k <= DEPTH; k++) hist[n-k] = '0;
            for (int c = 0; c < CH; c++) m_cnt[c] = 0;
            m_ovf    = '0;
            last_rst = n;
        end else begin
            hist[n] = toggle_i;
            for (int c = 0; c < CH; c++) begin
                bit inc, dec;
                inc = m_pulse[c];
                dec = ack_i[c] && (m_cnt[c] != 0);
                if (inc && !dec) begin
                    if (m_cnt[c] == MAXC) m_ovf[c] = 1'b1;
                    else begin
                        m_cnt[c]++;
                        if (ovf_clr_i[c]) m_ovf[c] = 1'b0;
                    end
                end else begin
                    if (dec && !inc) m_cnt[c]--;
                    if (ovf_clr_i[c]) m_ovf[c] = 1'b0;
                end
            end
        end
        if ((n - last_rst) >= DEPTH + 1) m_pulse = hist[n-DEPTH+1] ^ hist[n-DEPTH];
        else                             m_pulse = '0;
        #1;
        for (int c = 0; c < CH; c++) begin
            exp_cnt[c*CW +: CW] = CW'(m_cnt[c]);
            exp_val[c]          = (m_cnt[c] != 0);
            pseen[c]           += int'(pulse_o[c]);
        end
        chk("cyc_pulse", 32'(pulse_o), 32'(m_pulse));
        chk("cyc_count", 32'(count_o), 32'(exp_cnt));
        chk("cyc_valid", 32'(valid_o), 32'(exp_val));
        chk("cyc_ovf",   32'(ovf_o),   32'(m_ovf));
    endtask

    task automatic clr_seen();
        for (int c = 0; c < CH; c++) pseen[c] = 0;
    endtask

    initial begin
        for (int i = 0; i < HN; i++) hist[i] = '0;
        for (int c = 0; c < CH; c++) begin
            m_cnt[c] = 0; pseen[c] = 0; last_tog[c] = 0;
        end
        sys_rst = 1'b1; toggle_i = 4'b0001; ack_i = '0; ovf_clr_i = '0;

        // Reset/arming with ch0 held high: no event until it really toggles.
        tick(); tick();
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_ovf",   32'(ovf_o),   32'd0);
        sys_rst = 1'b0;
        clr_seen();
        repeat (10) tick();
        chk("arm_no_pulse", 32'(pseen[0]), 32'd0);
        chk("arm_count",    32'(count_o),  32'd0);
        toggle_i[0] = 1'b0;
        clr_seen();
        tick();
        chk("arm_early", 32'(pulse_o[0]), 32'd0);
        tick();
        chk("arm_lat", 32'(pulse_o[0]), 32'd1);
        repeat (4) tick();
        chk("arm_one_pulse", 32'(pseen[0]), 32'd1);

        // Latency on ch1.
        toggle_i[1] = 1'b1;
        tick(); tick();
        chk("lat_pulse", 32'(pulse_o[1]), 32'd1);
        tick();
        chk("lat_pulse_end", 32'(pulse_o[1]), 32'd0);
        chk("lat_count", 32'(count_o[7:4]), 32'd1);
        chk("lat_valid", 32'(valid_o[1]),   32'd1);
        ack_i[1] = 1'b1; tick(); ack_i[1] = 1'b0;
        tick();
        chk("lat_drain", 32'(count_o[7:4]), 32'd0);

        // Burst on ch2, then drain past zero.
        for (int i = 0; i < 5; i++) begin
            toggle_i[2] = ~toggle_i[2];
            repeat (3) tick();
        end
        repeat (3) tick();
        chk("burst_count", 32'(count_o[11:8]), 32'd5);
        chk("burst_ovf",   32'(ovf_o[2]),      32'd0);
        for (int i = 0; i < 5; i++) begin
            ack_i[2] = 1'b1; tick(); ack_i[2] = 1'b0;
            chk("burst_ack", 32'(count_o[11:8]), 32'(4 - i));
        end
        chk("burst_valid_drop", 32'(valid_o[2]), 32'd0);
        ack_i[2] = 1'b1; tick(); ack_i[2] = 1'b0;
        chk("burst_underflow", 32'(count_o[11:8]), 32'd0);

        // Saturation on ch3.
        for (int i = 0; i < 17; i++) begin
            toggle_i[3] = ~toggle_i[3];
            repeat (3) tick();
        end
        repeat (3) tick();
        chk("sat_count", 32'(count_o[15:12]), 32'd15);
        chk("sat_ovf",   32'(ovf_o[3]),       32'd1);
        toggle_i[3] = ~toggle_i[3];
        tick(); tick();
        chk("sat_pulse", 32'(pulse_o[3]), 32'd1);
        ack_i[3] = 1'b1; tick(); ack_i[3] = 1'b0;
        chk("sat_inc_dec", 32'(count_o[15:12]), 32'd15);
        ovf_clr_i[3] = 1'b1; tick(); ovf_clr_i[3] = 1'b0;
        chk("sat_clr", 32'(ovf_o[3]), 32'd0);
        tick();
        toggle_i[3] = ~toggle_i[3];
        tick(); tick();
        ovf_clr_i[3] = 1'b1; tick(); ovf_clr_i[3] = 1'b0;
        chk("sat_set_wins", 32'(ovf_o[3]),       32'd1);
        chk("sat_hold",     32'(count_o[15:12]), 32'd15);
        ovf_clr_i[3] = 1'b1; tick(); ovf_clr_i[3] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ack_i[3] = 1'b1; tick();
        end
        ack_i[3] = 1'b0;
        chk("sat_drain", 32'(count_o[15:12]), 32'd10);

        // All channels together; ch0 acks in its pulse cycle.
        toggle_i[0] = ~toggle_i[0];
        repeat (4) tick();
        chk("sim_pre", 32'(count_o[3:0]), 32'd2);
        toggle_i = ~toggle_i;
        tick(); tick();
        ack_i[0] = 1'b1; tick(); ack_i[0] = 1'b0;
        tick();
        chk("sim_counts", 32'(count_o), 32'h0000_B112);

        // Mid-operation reset with a toggle in flight.
        for (int i = 0; i < 2; i++) begin
            toggle_i[1] = ~toggle_i[1];
            repeat (3) tick();
        end
        repeat (2) tick();
        chk("mid_pre", 32'(count_o[7:4]), 32'd3);
        toggle_i[1] = ~toggle_i[1];
        tick();
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        chk("mid_count", 32'(count_o), 32'd0);
        chk("mid_valid", 32'(valid_o), 32'd0);
        clr_seen();
        repeat (DEPTH + 4) tick();
        chk("mid_no_pulse", 32'(pseen[0] + pseen[1] + pseen[2] + pseen[3]), 32'd0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < CH; c++) last_tog[c] = n;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ((n - last_tog[c]) >= 3 && $urandom_range(0, 2) == 0) begin
                    toggle_i[c] = ~toggle_i[c];
                    last_tog[c] = n;
                end
                ack_i[c]     = 1'($urandom_range(0, 2) == 0);
                ovf_clr_i[c] = 1'($urandom_range(0, 15) == 0);
            end
            sys_rst = 1'($urandom_range(0, 149) == 0);
            tick();
        end
        sys_rst = 1'b0; ack_i = '0; ovf_clr_i = '0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
